// File: rtl/mmio_bus_pkg.sv
// Shared definitions for the MMIO bus controller: FSM encoding, default sizes
// and the counter-width helper.
package mmio_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_N_SLV   = 5;
   localparam int DEF_TIMEOUT = 255;
   localparam int WAIT_W      = 4;

   function automatic int cnt_width(input int max_val);
      if (max_val < 2) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mmio_bus_if.sv
// CPU-side request bus and peripheral-side chip-select bus of the MMIO controller.
interface mmio_cpu_if
   import mmio_bus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              cpu_read;
   logic              cpu_write;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              cpu_err;

   modport master (output cpu_read, cpu_write, cpu_addr, cpu_wdata,
                   input  cpu_rdata, cpu_stall, cpu_err);
   modport slave  (input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
                   output cpu_rdata, cpu_stall, cpu_err);
endinterface

interface mmio_slv_if
   import mmio_bus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_SLV  = DEF_N_SLV
);
   logic [N_SLV-1:0]        cs;
   logic                    slv_read;
   logic                    slv_write;
   logic [ADDR_W-1:0]       slv_addr;
   logic [DATA_W-1:0]       slv_wdata;
   logic [N_SLV*DATA_W-1:0] slv_rdata;
   logic [N_SLV-1:0]        slv_ack;

   modport master (output cs, slv_read, slv_write, slv_addr, slv_wdata,
                   input  slv_rdata, slv_ack);
   modport slave  (input  cs, slv_read, slv_write, slv_addr, slv_wdata,
                   output slv_rdata, slv_ack);
endinterface

// File: rtl/mmio_wait_timer.sv
// Per-access timing: a loadable down-counter for fixed wait states and an
// up-counter that flags when an acknowledged access has waited too long.
module mmio_wait_timer
   import mmio_bus_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [WAIT_W-1:0] wait_val,
   output logic              wait_zero,
   output logic              to_expired
);
   localparam int TO_W = cnt_width(TIMEOUT);

   logic [WAIT_W-1:0] wait_cnt;
   logic [TO_W-1:0]   to_cnt;

   assign wait_zero  = (wait_cnt == '0);
   assign to_expired = (to_cnt == TO_W'(TIMEOUT));

   // Both counters saturate so they stay harmless once the access has ended.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         to_cnt   <= '0;
      end else if (load) begin
         wait_cnt <= wait_val;
         to_cnt   <= '0;
      end else if (step) begin
         if (!wait_zero)  wait_cnt <= wait_cnt - 1'b1;
         if (!to_expired) to_cnt   <= to_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: decodes a CPU access to one of N_SLV peripherals, holds
// the strobe for a fixed wait count or until that slave acknowledges, then returns data.
module mmio_bus_ctrl
   import mmio_bus_pkg::*;
#(
   parameter int                      ADDR_W   = DEF_ADDR_W,
   parameter int                      DATA_W   = DEF_DATA_W,
   parameter int                      N_SLV    = DEF_N_SLV,
   parameter int                      SEL_MSB  = 15,
   parameter int                      SEL_LSB  = 12,
   parameter logic [N_SLV*WAIT_W-1:0] WAIT_CYC = '0,
   parameter logic [N_SLV-1:0]        ACK_MODE = '0,
   parameter int                      TIMEOUT  = DEF_TIMEOUT
) (
   input logic        clk,
   input logic        rst,
   mmio_cpu_if.slave  cpu,
   mmio_slv_if.master slv
);
   localparam int SEL_W = SEL_MSB - SEL_LSB + 1;

   state_t            state;
   logic [SEL_W-1:0]  idx_q;
   logic [N_SLV-1:0]  cs_q;
   logic              rd_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic [SEL_W-1:0]  req_idx;
   logic              req_any;
   logic              req_hit;
   logic              req_ok;
   logic [N_SLV-1:0]  cs_ld;
   logic [WAIT_W-1:0] wait_ld;
   logic [DATA_W-1:0] rdata_sel;
   logic              ack_sel;
   logic              ack_mode_sel;
   logic              wait_zero;
   logic              to_expired;
   logic              acc_done;
   logic              acc_tmo;

   assign req_idx = cpu.cpu_addr[SEL_MSB:SEL_LSB];
   assign req_any = cpu.cpu_read | cpu.cpu_write;
   assign req_ok  = (cpu.cpu_read ^ cpu.cpu_write) && req_hit;

   // Decode of the incoming index and read-data/ack mux on the latched index.
   always_comb begin
      req_hit      = 1'b0;
      cs_ld        = '0;
      wait_ld      = '0;
      rdata_sel    = '0;
      ack_sel      = 1'b0;
      ack_mode_sel = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (req_idx == SEL_W'(i)) begin
            req_hit  = 1'b1;
            cs_ld[i] = 1'b1;
            wait_ld  = WAIT_CYC[i*WAIT_W +: WAIT_W];
         end
         if (idx_q == SEL_W'(i)) begin
            rdata_sel    = slv.slv_rdata[i*DATA_W +: DATA_W];
            ack_sel      = slv.slv_ack[i];
            ack_mode_sel = ACK_MODE[i];
         end
      end
   end

   // An acknowledge in the same cycle as expiry still counts as success.
   assign acc_done = ack_mode_sel ? ack_sel : wait_zero;
   assign acc_tmo  = ack_mode_sel && !ack_sel && to_expired;

   mmio_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       ((state == ST_IDLE) && req_ok),
      .step       (state == ST_ACCESS),
      .wait_val   (wait_ld),
      .wait_zero  (wait_zero),
      .to_expired (to_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx_q   <= '0;
         cs_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_ok) begin
                  idx_q   <= req_idx;
                  cs_q    <= cs_ld;
                  rd_q    <= cpu.cpu_read;
                  wr_q    <= cpu.cpu_write;
                  addr_q  <= cpu.cpu_addr;
                  wdata_q <= cpu.cpu_wdata;
                  state   <= ST_ACCESS;
               end else if (req_any) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state   <= ST_DONE;
               end
            end
            ST_ACCESS: begin
               if (acc_done || acc_tmo) begin
                  cs_q  <= '0;
                  rd_q  <= 1'b0;
                  wr_q  <= 1'b0;
                  err_q <= acc_tmo;
                  state <= ST_DONE;
                  if (acc_tmo)   rdata_q <= '0;
                  else if (rd_q) rdata_q <= rdata_sel;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cpu.cpu_stall = ((state == ST_IDLE) && req_any) || (state == ST_ACCESS);
   assign cpu.cpu_rdata = rdata_q;
   assign cpu.cpu_err   = err_q;
   assign slv.cs        = cs_q;
   assign slv.slv_read  = rd_q;
   assign slv.slv_write = wr_q;
   assign slv.slv_addr  = addr_q;
   assign slv.slv_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Scoreboard bench for mmio_bus_ctrl: the driver predicts each access outcome
// from the slave timing tables and a monitor compares what the bus shows.
module tb_mmio_bus_ctrl;

   localparam int         N    = 5;
   localparam int         TO   = 8;
   localparam logic [19:0] WAIT_P = {4'd0, 4'd1, 4'd3, 4'd0, 4'd2};
   localparam logic [4:0]  ACK_P  = 5'b10000;

   int wait_tbl [5] = '{2, 0, 3, 1, 0};
   bit ack_tbl  [5] = '{0, 0, 0, 0, 1};

   typedef struct {
      int          kind;   // 0 access, 1 reset check, 2 access aborted by reset
      int          issue;
      int          lat;
      int          n_acc;
      logic        err;
      logic        chk_rd;
      logic [15:0] rdata;
      logic [4:0]  cs;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cycle_no = 0;
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   bit   mon_en = 1'b0;
   bit   ack_en = 1'b0;
   int   ack_at = 0;
   int   cur_issue = 0;
   int   n_acc = 0;
   bit   acc_bad = 1'b0;
   logic [15:0] hold_rdata = '0;
   logic        hold_err = 1'b0;
   exp_t q[$];

   mmio_cpu_if #(.ADDR_W(16), .DATA_W(16))           cpu_bus ();
   mmio_slv_if #(.ADDR_W(16), .DATA_W(16), .N_SLV(N)) slv_bus ();

   mmio_bus_ctrl #(
      .ADDR_W(16), .DATA_W(16), .N_SLV(N), .SEL_MSB(15), .SEL_LSB(12),
      .WAIT_CYC(WAIT_P), .ACK_MODE(ACK_P), .TIMEOUT(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .cpu (cpu_bus.slave),
      .slv (slv_bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle_no++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cycle_no);
      end
   endtask

   // Peripheral model: other slaves ack randomly, the ack-mode slave acks on its scheduled cycle.
   always @(negedge clk) begin
      slv_bus.slv_ack[3:0] = 4'($urandom);
      slv_bus.slv_ack[4]   = ack_en && ((cycle_no - cur_issue) == ack_at);
   end

   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (mon_en) begin
         if (q.size() == 0) begin
            chk("idle_outputs",
                32'({cpu_bus.cpu_stall, slv_bus.cs, slv_bus.slv_read, slv_bus.slv_write,
                     cpu_bus.cpu_err, cpu_bus.cpu_rdata}),
                32'({1'b0, 5'b0, 1'b0, 1'b0, hold_err, hold_rdata}));
         end else begin
            e   = q[0];
            lat = cycle_no - e.issue;
            if (e.kind == 1) begin
               chk("reset_ctrl", 32'({cpu_bus.cpu_stall, slv_bus.cs, slv_bus.slv_read,
                                      slv_bus.slv_write, cpu_bus.cpu_err}), 32'd0);
               chk("reset_rdata", 32'(cpu_bus.cpu_rdata), 32'd0);
               chk("reset_addr_wdata", {slv_bus.slv_addr, slv_bus.slv_wdata}, 32'd0);
               hold_rdata = '0;
               hold_err   = 1'b0;
               void'(q.pop_front());
            end else if (e.kind == 2 && lat == e.lat) begin
               chk("abort_stall_follows_req", 32'(cpu_bus.cpu_stall), 32'd1);
               chk("abort_cs_strobes", 32'({slv_bus.cs, slv_bus.slv_read, slv_bus.slv_write}), 32'd0);
               chk("abort_addr_wdata", {slv_bus.slv_addr, slv_bus.slv_wdata}, 32'd0);
               chk("abort_rsp", 32'({cpu_bus.cpu_err, cpu_bus.cpu_rdata}), 32'd0);
               chk("abort_access_cycles", 32'(n_acc), 32'd2);
               chk("abort_access_signals", 32'(acc_bad), 32'd0);
               hold_rdata = '0;
               hold_err   = 1'b0;
               void'(q.pop_front());
            end else if (lat == 0) begin
               chk("stall_on_request", 32'(cpu_bus.cpu_stall), 32'd1);
               n_acc   = 0;
               acc_bad = 1'b0;
            end else if (lat > 300) begin
               chk("done_within_budget", 32'(lat), 32'(e.lat));
               void'(q.pop_front());
            end else if (cpu_bus.cpu_stall) begin
               n_acc++;
               if (slv_bus.cs !== e.cs || slv_bus.slv_read !== e.rd || slv_bus.slv_write !== e.wr ||
                   slv_bus.slv_addr !== e.addr || slv_bus.slv_wdata !== e.wdata)
                  acc_bad = 1'b1;
            end else begin
               logic [15:0] exp_rd;
               exp_rd = e.chk_rd ? e.rdata : hold_rdata;
               chk("done_latency", 32'(lat), 32'(e.lat));
               chk("access_cycles", 32'(n_acc), 32'(e.n_acc));
               chk("access_signals", 32'(acc_bad), 32'd0);
               chk("done_cs_strobes", 32'({slv_bus.cs, slv_bus.slv_read, slv_bus.slv_write}), 32'd0);
               chk("cpu_err", 32'(cpu_bus.cpu_err), 32'(e.err));
               chk("cpu_rdata", 32'(cpu_bus.cpu_rdata), 32'(exp_rd));
               hold_rdata = exp_rd;
               hold_err   = e.err;
               done_cnt++;
               void'(q.pop_front());
            end
         end
      end
   end

   // Caller is positioned just after a rising edge; returns just after a rising edge.
   task automatic issue_txn(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input int ack_cyc, input bit drop,
                            input int slot, input logic [15:0] sval);
      exp_t e;
      int   idx;
      int   d0;
      int   k;
      for (int i = 0; i < N; i++) slv_bus.slv_rdata[i*16 +: 16] = 16'($urandom);
      if (slot >= 0) slv_bus.slv_rdata[slot*16 +: 16] = sval;
      idx     = int'(addr[15:12]);
      e.kind  = 0;
      e.rd    = rd;
      e.wr    = wr;
      e.addr  = addr;
      e.wdata = wdata;
      e.cs    = (idx < N) ? (5'd1 << idx) : 5'd0;
      if ((rd && wr) || idx >= N) begin
         e.lat = 1; e.n_acc = 0; e.err = 1'b1; e.chk_rd = 1'b1; e.rdata = '0;
      end else if (ack_tbl[idx]) begin
         if (ack_cyc >= 1 && ack_cyc <= TO + 1) begin
            e.lat = ack_cyc + 1; e.n_acc = ack_cyc; e.err = 1'b0; e.chk_rd = rd;
            e.rdata = slv_bus.slv_rdata[idx*16 +: 16];
         end else begin
            e.lat = TO + 2; e.n_acc = TO + 1; e.err = 1'b1; e.chk_rd = 1'b1; e.rdata = '0;
         end
      end else begin
         e.lat = wait_tbl[idx] + 2; e.n_acc = wait_tbl[idx] + 1; e.err = 1'b0; e.chk_rd = rd;
         e.rdata = slv_bus.slv_rdata[idx*16 +: 16];
      end
      cpu_bus.cpu_read  = rd;
      cpu_bus.cpu_write = wr;
      cpu_bus.cpu_addr  = addr;
      cpu_bus.cpu_wdata = wdata;
      e.issue   = cycle_no;
      cur_issue = cycle_no;
      ack_at    = ack_cyc;
      ack_en    = (ack_cyc > 0);
      d0        = done_cnt;
      q.push_back(e);
      if (drop) begin
         @(posedge clk); #1;
         cpu_bus.cpu_read  = 1'b0;
         cpu_bus.cpu_write = 1'b0;
      end
      k = 0;
      while (done_cnt == d0 && k < 400) begin
         @(negedge clk); #1;
         k++;
      end
      if (done_cnt == d0) chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
      @(posedge clk); #1;
      cpu_bus.cpu_read  = 1'b0;
      cpu_bus.cpu_write = 1'b0;
      ack_en            = 1'b0;
   endtask

   task automatic abort_txn(input logic [15:0] addr, input logic [15:0] wdata);
      exp_t e;
      e.kind = 2; e.lat = 3; e.n_acc = 2; e.err = 1'b0; e.chk_rd = 1'b0; e.rdata = '0;
      e.rd = 1'b0; e.wr = 1'b1; e.addr = addr; e.wdata = wdata;
      e.cs = 5'd1 << int'(addr[15:12]);
      cpu_bus.cpu_write = 1'b1;
      cpu_bus.cpu_addr  = addr;
      cpu_bus.cpu_wdata = wdata;
      e.issue = cycle_no;
      q.push_back(e);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      cpu_bus.cpu_write = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [3:0] ridx;
      int         op;
      rst = 1'b1;
      cpu_bus.cpu_read  = 1'b0;
      cpu_bus.cpu_write = 1'b0;
      cpu_bus.cpu_addr  = '0;
      cpu_bus.cpu_wdata = '0;
      slv_bus.slv_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      begin
         exp_t r;
         r = '{kind: 1, issue: cycle_no, lat: 0, n_acc: 0, err: 1'b0, chk_rd: 1'b0,
               rdata: '0, cs: '0, rd: 1'b0, wr: 1'b0, addr: '0, wdata: '0};
         q.push_back(r);
      end
      mon_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      issue_txn(1'b1, 1'b0, 16'h1004, 16'h0000, 0, 1'b0, 1, 16'hBEEF);
      issue_txn(1'b0, 1'b1, 16'h2000, 16'h1234, 0, 1'b0, -1, 16'h0);
      issue_txn(1'b1, 1'b0, 16'h7000, 16'h0000, 0, 1'b0, -1, 16'h0);
      issue_txn(1'b1, 1'b0, 16'h4010, 16'h0000, 0, 1'b0, -1, 16'h0);
      issue_txn(1'b1, 1'b0, 16'h4010, 16'h0000, 3, 1'b0, 4, 16'h00A5);
      issue_txn(1'b1, 1'b1, 16'h1000, 16'h5555, 0, 1'b0, -1, 16'h0);
      issue_txn(1'b1, 1'b0, 16'h0ABC, 16'h0000, 0, 1'b1, 0, 16'h3C3C);
      issue_txn(1'b0, 1'b1, 16'h4002, 16'h9999, 9, 1'b0, -1, 16'h0);
      abort_txn(16'h2468, 16'hCAFE);

      for (int t = 0; t < 60; t++) begin
         ridx = 4'($urandom_range(0, 7));
         op   = $urandom_range(0, 9);
         issue_txn((op == 0) || (op >= 5), (op >= 1 && op <= 4) || (op == 0),
                   {ridx, 12'($urandom)}, 16'($urandom),
                   $urandom_range(0, 11), ($urandom_range(0, 3) == 0), -1, 16'h0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
